y86_imem_loader: RTL and testbench
==================================

Name: y86_imem_loader

Overview:
- Instruction encoder and loader for the Y-86 pipeline.
- Accepts decoded instruction fields (icode, ifun, rA, rB, valC) over a valid/ready handshake.
- Serializes each instruction into its Y-86 byte encoding and writes the bytes, one per cycle, into the byte-wide instruction memory that the fetch stage reads.
- Sits between the testbench/program source and the instruction memory write port. It is the writer end of the fetch stage's byte-level instruction format.

Parameters:
- ADDR_W, 10, instruction memory byte-address width.
- MEM_DEPTH, 1024, number of instruction memory bytes; legal addresses are 0 .. MEM_DEPTH-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- base_load  in  1  load write pointer from base_addr; honoured only in IDLE, DONE or ERR.
- base_addr  in  ADDR_W  new write pointer value.
- in_valid  in  1  instruction descriptor valid.
- in_ready  out  1  loader can accept a descriptor.
- in_icode  in  4  instruction code.
- in_ifun  in  4  function code.
- in_rA  in  4  register A.
- in_rB  in  4  register B.
- in_valC  in  64  constant or destination word.
- mem_we  out  1  instruction memory byte write enable.
- mem_addr  out  ADDR_W  write byte address.
- mem_wdata  out  8  write byte.
- wr_ptr  out  ADDR_W  next free byte address.
- instr_count  out  16  instructions written since reset or base_load; saturates at 0xFFFF.
- done  out  1  one-cycle pulse in the cycle the last byte of an instruction is written.
- err  out  1  sticky error flag.

Behaviour:
- Reset: state IDLE. Clear wr_ptr, instr_count, err, mem_we, mem_addr, mem_wdata and done; in_ready=0 during reset. Reset mid-emission aborts the instruction; bytes already written stay in memory.
- States:
  - IDLE: in_ready=1.
  - EMIT: in_ready=0.
  - ERR: in_ready=0.
  - DONE: exists only with HALT_TERM_EN; in_ready=0.
- Accept occurs when in_valid && in_ready. Fields are captured into registers on accept, so inputs may change afterwards.
- Length table (icode -> bytes):
  - 0, 1, 9 -> 1
  - 2, 6, A, B -> 2
  - 7, 8 -> 9
  - 3, 4, 5 -> 10
- Byte layout:
  - Byte 0 = {icode, ifun}.
  - Lengths 2 and 10: byte 1 = {rA, rB}.
  - valC is written MSB first: bytes 2..9 for icodes 3/4/5, bytes 1..8 for icodes 7/8. The first valC byte = valC[63:56].
  - Forced register fields: irmovq writes rA=F. pushq and popq write rB=F.
- Timing:
  - Accept at edge T. Byte k is driven on mem_* during cycle T+1+k, with mem_we registered high.
  - done pulses with the last byte. wr_ptr advances by len in that same cycle. instr_count increments by 1.
  - The machine returns to IDLE, and in_ready is high the following cycle. Throughput is len+1 cycles per instruction.
- Invalid icode (>0xB) on accept: nothing is written, err=1, state ERR.
- Overflow: if wr_ptr+len > MEM_DEPTH on accept (computed at ADDR_W+4 bits), nothing is written, err=1, state ERR. No partial instruction and no wrap-around ever occurs.
- base_load: in IDLE/ERR/DONE, sets wr_ptr=base_addr, clears instr_count and err, and enters IDLE. While in EMIT it is ignored. If base_load and in_valid arrive in the same IDLE cycle, base_load wins and the descriptor is not accepted (in_ready is forced low that cycle).
- mem_we=0 in all states other than EMIT. mem_addr and mem_wdata hold their last values when mem_we=0.

Optional Feature:
- Macro: Y86_LOADER_HALT_TERM_EN.
- When defined: after a halt (icode 0) byte is written, the FSM enters DONE. In DONE, in_ready=0 until base_load or rst.
- When undefined: halt is an ordinary 1-byte instruction and the FSM returns to IDLE.

Decomposition:
- Package y86_pkg holds:
  - icode localparams (HALT=0 .. POPQ=B);
  - a function returning instruction length from icode (0 for invalid);
  - the loader state enum;
  - the register code constant RNONE=4'hF.
- One sub-module, y86_instr_byte_sel: a combinational selector from (captured fields, byte index) to mem_wdata. The top module keeps the FSM, pointer and counters.

Test Plan:
- From reset, send irmovq icode 3, rB=3, valC=0x100 -> writes 30 F3 00 00 00 00 00 00 01 00 to addresses 0..9; done pulses at the 10th byte; wr_ptr=10; instr_count=1.
- Send irmovq rB=2 valC=0x200, then OPq ifun 3 rA=2 rB=3, then halt back-to-back -> addresses 10..22 hold 30 F2 00 00 00 00 00 00 02 00 63 23 00; in_ready is low exactly len cycles after each accept.
- base_load base_addr=0x3F8, then send call valC=0x1E -> 9 bytes written at 0x3F8..0x400? No: that would need 0x400. Required result: rejected, err=1, no mem_we. Repeat with base_addr=0x3F7 -> 80 00 00 00 00 00 00 00 1E at 0x3F7..0x3FF, wr_ptr=0x400.
- Send icode 0xC -> err=1, no writes, in_ready=0; then base_load -> err=0, in_ready=1.
- Assert rst during byte 4 of an rmmovq -> next cycle mem_we=0, wr_ptr=0, in_ready=1 one cycle after rst deasserts.
- With Y86_LOADER_HALT_TERM_EN, send halt then nop -> byte 00 written, in_ready stays 0, nop not accepted until base_load.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y-86 definitions for the instruction loader: icodes, register
// constants, loader state encoding and the icode-to-length table.
package y86_pkg;

  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] RRMOVQ = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;

  localparam logic [3:0] RNONE  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_ERR  = 2'd2,
    ST_DONE = 2'd3
  } ldr_state_e;

  // Encoded byte length of an instruction; 0 marks an invalid icode.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    logic [3:0] len;
    case (icode)
      HALT, NOP, RET:            len = 4'd1;
      RRMOVQ, OPQ, PUSHQ, POPQ:  len = 4'd2;
      JXX, CALL:                 len = 4'd9;
      IRMOVQ, RMMOVQ, MRMOVQ:    len = 4'd10;
      default:                   len = 4'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/y86_instr_byte_sel.sv
// Combinational selector: picks byte number byte_idx_i of the Y-86 encoding
// of one instruction (valC emitted most-significant byte first).
module y86_instr_byte_sel
  import y86_pkg::*;
(
  input  logic [3:0]  icode_i,
  input  logic [3:0]  ifun_i,
  input  logic [3:0]  ra_i,
  input  logic [3:0]  rb_i,
  input  logic [63:0] valc_i,
  input  logic [3:0]  byte_idx_i,
  output logic [7:0]  byte_o
);

  logic [7:0] valc_bytes [8];
  logic [3:0] ra_eff;
  logic [3:0] rb_eff;
  logic [2:0] vc_idx;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_valc_byte
      assign valc_bytes[gi] = valc_i[63-8*gi -: 8];
    end
  endgenerate

  always_comb begin
    ra_eff = (icode_i == IRMOVQ) ? RNONE : ra_i;
    rb_eff = (icode_i == PUSHQ || icode_i == POPQ) ? RNONE : rb_i;
    vc_idx = 3'd0;
    byte_o = 8'h00;
    if (byte_idx_i == 4'd0) begin
      byte_o = {icode_i, ifun_i};
    end else begin
      case (icode_i)
        IRMOVQ, RMMOVQ, MRMOVQ: begin
          if (byte_idx_i == 4'd1) begin
            byte_o = {ra_eff, rb_eff};
          end else begin
            vc_idx = 3'(byte_idx_i - 4'd2);
            byte_o = valc_bytes[vc_idx];
          end
        end
        JXX, CALL: begin
          vc_idx = 3'(byte_idx_i - 4'd1);
          byte_o = valc_bytes[vc_idx];
        end
        RRMOVQ, OPQ, PUSHQ, POPQ: byte_o = {ra_eff, rb_eff};
        default:                  byte_o = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/y86_imem_loader.sv
// Y-86 instruction encoder/loader: serialises accepted descriptors into the
// byte-wide instruction memory. Y86_LOADER_HALT_TERM_EN parks the FSM after halt.
module y86_imem_loader
  import y86_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_icode,
  input  logic [3:0]        in_ifun,
  input  logic [3:0]        in_rA,
  input  logic [3:0]        in_rB,
  input  logic [63:0]       in_valC,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [15:0]       instr_count,
  output logic              done,
  output logic              err
);

  localparam int CW = ADDR_W + 4;

  ldr_state_e        state_q, state_d;
  // One extra bit so a completely filled memory reads as MEM_DEPTH, not 0.
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic [3:0]        icode_q, icode_d;
  logic [3:0]        ifun_q, ifun_d;
  logic [3:0]        ra_q, ra_d;
  logic [3:0]        rb_q, rb_d;
  logic [63:0]       valc_q, valc_d;
  logic [3:0]        len_q, len_d;
  logic [3:0]        idx_q, idx_d;

  logic              accept;
  logic              idle;
  logic              emit;
  logic [3:0]        in_len;
  logic [3:0]        cur_len;
  logic [CW-1:0]     end_addr;
  logic              overflow;
  logic [3:0]        sel_icode, sel_ifun, sel_ra, sel_rb, sel_idx;
  logic [63:0]       sel_valc;
  logic [7:0]        sel_byte;

  assign idle     = (state_q == ST_IDLE);
  assign in_ready = idle && !base_load && !rst;
  assign accept   = in_valid && in_ready;
  assign in_len   = instr_len(in_icode);
  assign end_addr = CW'(ptr_q) + CW'(in_len);
  assign overflow = end_addr > CW'(MEM_DEPTH);

  // Byte 0 goes out on the accept edge, before the fields are captured.
  assign sel_icode = idle ? in_icode : icode_q;
  assign sel_ifun  = idle ? in_ifun  : ifun_q;
  assign sel_ra    = idle ? in_rA    : ra_q;
  assign sel_rb    = idle ? in_rB    : rb_q;
  assign sel_valc  = idle ? in_valC  : valc_q;
  assign sel_idx   = idle ? 4'd0     : idx_q;
  assign cur_len   = idle ? in_len   : len_q;

  y86_instr_byte_sel u_byte_sel (
    .icode_i    (sel_icode),
    .ifun_i     (sel_ifun),
    .ra_i       (sel_ra),
    .rb_i       (sel_rb),
    .valc_i     (sel_valc),
    .byte_idx_i (sel_idx),
    .byte_o     (sel_byte)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    icode_d     = icode_q;
    ifun_d      = ifun_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    valc_d      = valc_q;
    len_d       = len_q;
    idx_d       = idx_q;
    emit        = 1'b0;

    if (base_load && state_q != ST_EMIT) begin
      state_d = ST_IDLE;
      ptr_d   = {1'b0, base_addr};
      cnt_d   = 16'd0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            icode_d = in_icode;
            ifun_d  = in_ifun;
            ra_d    = in_rA;
            rb_d    = in_rB;
            valc_d  = in_valC;
            len_d   = in_len;
            if (in_len == 4'd0 || overflow) begin
              err_d   = 1'b1;
              state_d = ST_ERR;
            end else begin
              emit    = 1'b1;
              idx_d   = 4'd1;
              state_d = ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (idx_q == len_q) begin
`ifdef Y86_LOADER_HALT_TERM_EN
            state_d = (icode_q == HALT) ? ST_DONE : ST_IDLE;
`else
            state_d = ST_IDLE;
`endif
          end else begin
            emit  = 1'b1;
            idx_d = idx_q + 4'd1;
          end
        end
        default: ;
      endcase
    end

    if (emit) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = ptr_q[ADDR_W-1:0] + ADDR_W'(sel_idx);
      mem_wdata_d = sel_byte;
      if (sel_idx == cur_len - 4'd1) begin
        done_d = 1'b1;
        ptr_d  = ptr_q + (ADDR_W+1)'(cur_len);
        cnt_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      icode_q     <= '0;
      ifun_q      <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      valc_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      icode_q     <= icode_d;
      ifun_q      <= ifun_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      valc_q      <= valc_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign wr_ptr      = ptr_q[ADDR_W-1:0];
  assign instr_count = cnt_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_y86_imem_loader.sv
// Directed bench for y86_imem_loader: logs memory writes and checks bytes,
// pointers, handshake timing, error paths and reset abort against fixed values.
module tb_y86_imem_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              base_load;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_icode, in_ifun, in_rA, in_rB;
  logic [63:0]       in_valC;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [ADDR_W-1:0] wr_ptr;
  logic [15:0]       instr_count;
  logic              done;
  logic              err;

  int vectors = 0;
  int miscompares = 0;
  int wcount = 0;
  int dcount = 0;
  logic [ADDR_W-1:0] done_addr = '0;
  logic [7:0] tmem [1024];

  y86_imem_loader #(.ADDR_W(ADDR_W), .MEM_DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .base_load(base_load), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_icode(in_icode),
    .in_ifun(in_ifun), .in_rA(in_rA), .in_rB(in_rB), .in_valC(in_valC),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .wr_ptr(wr_ptr), .instr_count(instr_count), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      tmem[mem_addr] <= mem_wdata;
      wcount <= wcount + 1;
    end
    if (done) begin
      dcount <= dcount + 1;
      done_addr <= mem_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [63:0] vc);
    in_icode = ic; in_ifun = fn; in_rA = ra; in_rB = rb; in_valC = vc;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !in_ready; i++) tick();
    chk("accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    // scramble inputs: the loader must work from its captured copy
    in_icode = 4'hE; in_ifun = 4'hE; in_rA = 4'hE; in_rB = 4'hE; in_valC = ~vc;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic load(input logic [ADDR_W-1:0] a);
    base_addr = a;
    base_load = 1'b1;
    tick();
    base_load = 1'b0;
    #1;
  endtask

  logic [7:0] exp1 [10] = '{8'h30, 8'hF3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
  logic [7:0] exp2 [13] = '{8'h30, 8'hF2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00,
                            8'h63, 8'h23, 8'h00};
  logic [7:0] exp3 [9]  = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1E};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int w0;
    rst = 1'b1; base_load = 1'b0; base_addr = '0; in_valid = 1'b0;
    in_icode = '0; in_ifun = '0; in_rA = '0; in_rB = '0; in_valC = '0;

    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_wr_ptr", wr_ptr, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_err", err, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1);

    // irmovq $0x100, %rbx (rA input deliberately not F)
    w0 = wcount;
    send(4'h3, 4'h0, 4'h0, 4'h3, 64'h100);
    wait_ready(n);
    chk("irmov1_busy", n, 10);
    chk("irmov1_writes", wcount - w0, 10);
    chk("irmov1_dones", dcount, 1);
    chk("irmov1_done_addr", done_addr, 9);
    chk("irmov1_wr_ptr", wr_ptr, 10);
    chk("irmov1_count", instr_count, 1);
    chk("idle_we", mem_we, 0);
    chk("idle_hold_addr", mem_addr, 9);
    chk("idle_hold_data", mem_wdata, 8'h00);
    for (int i = 0; i < 10; i++) chk($sformatf("irmov1_b%0d", i), tmem[i], exp1[i]);

    // back-to-back irmovq, addq-style OPq ifun 3, halt
    send(4'h3, 4'h0, 4'h7, 4'h2, 64'h200);
    wait_ready(n);
    chk("irmov2_busy", n, 10);
    send(4'h6, 4'h3, 4'h2, 4'h3, 64'h0);
    wait_ready(n);
    chk("opq_busy", n, 2);
    w0 = wcount;
    send(4'h0, 4'h0, 4'h0, 4'h0, 64'h0);
    wait_ready(n);
`ifdef Y86_LOADER_HALT_TERM_EN
    chk("halt_parked", n, 40);
    chk("halt_written", wcount - w0, 1);
    w0 = wcount;
    in_icode = 4'h1; in_ifun = 4'h0; in_valid = 1'b1;
    repeat (3) tick();
    chk("done_ready_low", in_ready, 0);
    chk("done_nop_blocked", wcount - w0, 0);
    in_valid = 1'b0;
`else
    chk("halt_busy", n, 1);
    chk("halt_written", wcount - w0, 1);
`endif
    for (int i = 0; i < 13; i++) chk($sformatf("seq_b%0d", 10 + i), tmem[10 + i], exp2[i]);
    chk("seq_wr_ptr", wr_ptr, 23);
    chk("seq_count", instr_count, 4);

    // call that would run past the top of memory is refused
    load(10'h3F8);
    chk("bl_ready", in_ready, 1);
    chk("bl_wr_ptr", wr_ptr, 10'h3F8);
    chk("bl_count", instr_count, 0);
    w0 = wcount;
    send(4'h8, 4'h0, 4'h0, 4'h0, 64'h1E);
    repeat (3) tick();
    chk("ovf_err", err, 1);
    chk("ovf_ready", in_ready, 0);
    chk("ovf_writes", wcount - w0, 0);
    chk("ovf_we", mem_we, 0);

    // same call one byte lower fits exactly
    load(10'h3F7);
    chk("bl2_err", err, 0);
    chk("bl2_ready", in_ready, 1);
    send(4'h8, 4'h0, 4'h0, 4'h0, 64'h1E);
    wait_ready(n);
    chk("call_busy", n, 9);
    for (int i = 0; i < 9; i++) chk($sformatf("call_b%0d", i), tmem[10'h3F7 + i], exp3[i]);
    // pointer now equals 0x400, which reads as 0 on the 10-bit port
    chk("call_wr_ptr", wr_ptr, 10'h000);
    chk("call_count", instr_count, 1);
    w0 = wcount;
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
    tick();
    chk("full_err", err, 1);
    chk("full_no_wrap", wcount - w0, 0);

    // invalid icode
    load(10'h000);
    w0 = wcount;
    send(4'hC, 4'h0, 4'h0, 4'h0, 64'h0);
    tick();
    chk("badic_err", err, 1);
    chk("badic_ready", in_ready, 0);
    chk("badic_writes", wcount - w0, 0);
    load(10'h100);
    chk("badic_clr_err", err, 0);
    chk("badic_clr_ready", in_ready, 1);

    // reset while rmmovq byte 4 is on the bus
    send(4'h4, 4'h0, 4'h1, 4'h2, 64'h0123456789ABCDEF);
    repeat (4) tick();
    chk("rm_b4_we", mem_we, 1);
    chk("rm_b4_addr", mem_addr, 10'h104);
    chk("rm_b4_data", mem_wdata, 8'h45);
    rst = 1'b1;
    tick();
    chk("abort_we", mem_we, 0);
    chk("abort_wr_ptr", wr_ptr, 0);
    chk("abort_count", instr_count, 0);
    rst = 1'b0;
    #1;
    chk("abort_ready", in_ready, 1);
    chk("abort_kept_b1", tmem[10'h101], 8'h12);
    chk("abort_kept_b4", tmem[10'h104], 8'h45);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
